// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int PARITY_NONE = 32'sd0;
   localparam int PARITY_EVEN = 32'sd1;
   localparam int PARITY_ODD  = 32'sd2;

   // Parity over up to 9 data bits; unused upper bits are zero and do not
   // change the XOR. Odd mode is the inverse of even mode.
   function automatic logic parity_bit(input logic [8:0] data, input int mode);
      logic p;
      p = ^data;
      if (mode == PARITY_ODD) begin
         return ~p;
      end else begin
         return p;
      end
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_tick for one cycle on the terminal count. restart clears it synchronously.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic enable,
   output logic bit_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 32'sd1);

   logic [CW-1:0] cnt_r;

   // Bit-period counter, held at zero whenever the transmitter is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (restart) begin
         cnt_r <= {CW{1'b0}};
      end else if (enable) begin
         if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_r <= {CW{1'b0}};
      end
   end

   assign bit_tick = enable & (cnt_r == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and sends start bit,
// LSB-first data, optional parity and stop bits on a registered tx line.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   import uart_pkg::*;

   localparam int BCW = $clog2(DATA_BITS + 32'sd1);
   localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 32'sd1);
   localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 32'sd1);

   if (CLKS_PER_BIT < 32'sd2) begin : g_bad_cpb
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end
   if (DATA_BITS < 32'sd5 || DATA_BITS > 32'sd9) begin : g_bad_bits
      $error("uart_tx: DATA_BITS must be in 5..9");
   end
   if (PARITY < 32'sd0 || PARITY > 32'sd2) begin : g_bad_par
      $error("uart_tx: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 32'sd1 || STOP_BITS > 32'sd2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   uart_state_t          state_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [BCW-1:0]       bit_cnt_r;
   logic                 parity_r;
   logic                 tx_r;
   logic                 ready_r;
   logic                 busy_r;
   logic                 accept_s;
   logic                 enable_s;
   logic                 tick_s;

   assign accept_s = tx_valid & ready_r;
   assign enable_s = (state_r != IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (accept_s),
      .enable  (enable_s),
      .bit_tick(tick_s)
   );

   // Frame sequencer: owns state, shift register, bit counter and all outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         shift_r   <= {DATA_BITS{1'b0}};
         bit_cnt_r <= {BCW{1'b0}};
         parity_r  <= 1'b0;
         tx_r      <= 1'b1;
         ready_r   <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r   <= START;
                  shift_r   <= tx_data;
                  parity_r  <= parity_bit(9'(tx_data), PARITY);
                  bit_cnt_r <= {BCW{1'b0}};
                  tx_r      <= 1'b0;
                  ready_r   <= 1'b0;
                  busy_r    <= 1'b1;
               end else begin
                  tx_r <= 1'b1;
               end
            end
            START: begin
               if (tick_s) begin
                  state_r   <= DATA;
                  tx_r      <= shift_r[0];
                  shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                  bit_cnt_r <= {BCW{1'b0}};
               end else begin
                  tx_r <= 1'b0;
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (bit_cnt_r == LAST_DATA) begin
                     bit_cnt_r <= {BCW{1'b0}};
                     // Parity mode is a parameter, so only one branch survives elaboration.
                     if (PARITY != PARITY_NONE) begin
                        state_r <= uart_pkg::PARITY;
                        tx_r    <= parity_r;
                     end else begin
                        state_r <= STOP;
                        tx_r    <= 1'b1;
                     end
                  end else begin
                     tx_r      <= shift_r[0];
                     shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                     bit_cnt_r <= bit_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
                  end
               end else begin
                  tx_r <= tx_r;
               end
            end
            uart_pkg::PARITY: begin
               if (tick_s) begin
                  state_r   <= STOP;
                  tx_r      <= 1'b1;
                  bit_cnt_r <= {BCW{1'b0}};
               end else begin
                  tx_r <= parity_r;
               end
            end
            STOP: begin
               if (tick_s) begin
                  if (bit_cnt_r == LAST_STOP) begin
                     state_r   <= IDLE;
                     bit_cnt_r <= {BCW{1'b0}};
                     ready_r   <= 1'b1;
                     busy_r    <= 1'b0;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
                  end
               end else begin
                  bit_cnt_r <= bit_cnt_r;
               end
               tx_r <= 1'b1;
            end
            default: begin
               state_r   <= IDLE;
               bit_cnt_r <= {BCW{1'b0}};
               tx_r      <= 1'b1;
               ready_r   <= 1'b1;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign tx       = tx_r;
   assign tx_ready = ready_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three configurations at 4 clocks per bit, with
// a line-level scoreboard and a mid-bit byte decoder.
module tb_uart_tx;

   logic       clk;
   logic       rst_n;
   logic [7:0] data [3];
   logic [2:0] valid;
   logic [2:0] ready;
   logic [2:0] line;
   logic [2:0] busy;

   int   vectors = 0;
   int   errs    = 0;
   logic q_lvl [$];
   logic [7:0] q_byte [$];
   logic samp [0:127];

   uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .tx(line[0]), .busy(busy[0]));

   uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
      .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .tx(line[1]), .busy(busy[1]));

   uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_c (
      .clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .tx(line[2]), .busy(busy[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame: 4 samples per bit, start, LSB-first data, parity, stops.
   task automatic push_frame(input logic [7:0] b, input int par, input int stops);
      logic p;
      for (int k = 0; k < 4; k++) q_lvl.push_back(1'b0);
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 4; k++) q_lvl.push_back(b[j]);
      if (par != 0) begin
         p = (par == 2) ? ~(^b) : (^b);
         for (int k = 0; k < 4; k++) q_lvl.push_back(p);
      end
      for (int s = 0; s < stops * 4; s++) q_lvl.push_back(1'b1);
   endtask

   // Offer a byte and return right after the accepting rising edge.
   task automatic send(input int i, input logic [7:0] b, input int par, input int stops);
      int guard;
      guard = 0;
      @(negedge clk);
      data[i]  = b;
      valid[i] = 1'b1;
      while (ready[i] !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("accept_timeout", 16'd0, 16'd1);
      push_frame(b, par, stops);
      q_byte.push_back(b);
      @(posedge clk);
   endtask

   // Sample the line once per cycle after the accept edge and compare to the scoreboard.
   task automatic watch(input int i, input int ncyc, input int rdy_at, input int drop_at,
                        input int chg_at, input logic [7:0] chg_val);
      logic exp;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (q_lvl.size() > 0) exp = q_lvl.pop_front();
         else exp = 1'bx;
         samp[c] = line[i];
         chk($sformatf("tx_i%0d_c%0d", i, c), {15'd0, line[i]}, {15'd0, exp});
         chk($sformatf("ready_i%0d_c%0d", i, c), {15'd0, ready[i]}, {15'd0, (c == rdy_at)});
         chk($sformatf("busy_i%0d_c%0d", i, c), {15'd0, busy[i]}, {15'd0, (c != rdy_at)});
         if (c == drop_at) valid[i] = 1'b0;
         if (c == chg_at) data[i] = chg_val;
      end
   endtask

   task automatic end_check(input int i);
      @(negedge clk);
      chk($sformatf("end_ready_i%0d", i), {15'd0, ready[i]}, 16'd1);
      chk($sformatf("end_busy_i%0d", i), {15'd0, busy[i]}, 16'd0);
      chk($sformatf("end_tx_i%0d", i), {15'd0, line[i]}, 16'd1);
   endtask

   // Recover a byte from captured samples by reading each data bit mid-period.
   task automatic decode(input int c0);
      logic [7:0] got;
      logic [7:0] exp;
      chk($sformatf("dec_start_c%0d", c0), {15'd0, samp[c0]}, 16'd0);
      for (int j = 0; j < 8; j++) got[j] = samp[c0 + (1 + j) * 4 + 2];
      if (q_byte.size() > 0) exp = q_byte.pop_front();
      else exp = 8'hxx;
      chk($sformatf("dec_byte_c%0d", c0), {8'd0, got}, {8'd0, exp});
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 3'b000;
      for (int i = 0; i < 3; i++) data[i] = 8'h00;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_tx_i%0d", i), {15'd0, line[i]}, 16'd1);
         chk($sformatf("rst_ready_i%0d", i), {15'd0, ready[i]}, 16'd1);
         chk($sformatf("rst_busy_i%0d", i), {15'd0, busy[i]}, 16'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Basic 8N1 frame of 0x55
      send(0, 8'h55, 0, 1);
      watch(0, 40, -1, 0, -1, 8'h00);
      end_check(0);
      decode(0);

      // Even parity, 0x07 -> parity bit 1, 44 cycles
      send(1, 8'h07, 1, 1);
      watch(1, 44, -1, 0, -1, 8'h00);
      end_check(1);
      decode(0);

      // Odd parity with two stop bits, 0x00 -> parity bit 1, 48 cycles
      send(2, 8'h00, 2, 2);
      watch(2, 48, -1, 0, -1, 8'h00);
      end_check(2);
      decode(0);

      // Back-to-back with valid held: one idle cycle between frames
      send(0, 8'hA5, 0, 1);
      q_lvl.push_back(1'b1);
      push_frame(8'h3C, 0, 1);
      q_byte.push_back(8'h3C);
      watch(0, 81, 40, 41, 0, 8'h3C);
      end_check(0);
      decode(0);
      decode(41);

      // tx_data changes after accept must not alter the frame
      send(0, 8'h81, 0, 1);
      watch(0, 40, -1, 0, 1, 8'hFF);
      end_check(0);
      decode(0);

      // Reset during data bit 3: line and ready recover without a clock edge
      send(0, 8'hC3, 0, 1);
      watch(0, 18, -1, 0, -1, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_tx", {15'd0, line[0]}, 16'd1);
      chk("midrst_ready", {15'd0, ready[0]}, 16'd1);
      chk("midrst_busy", {15'd0, busy[0]}, 16'd0);
      q_lvl.delete();
      q_byte.delete();
      @(negedge clk);
      rst_n = 1'b1;
      send(0, 8'h12, 0, 1);
      watch(0, 40, -1, 0, -1, 8'h00);
      end_check(0);
      decode(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
